// File: rtl/sprite_pkg.sv
// Shared constants, sprite ROM entry layout and scheduler state encoding
// for the sprite draw scheduler.
package sprite_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int DX_MSB  = 15;
  localparam int DX_LSB  = 11;
  localparam int DY_MSB  = 10;
  localparam int DY_LSB  = 6;
  localparam int COL_MSB = 5;
  localparam int COL_LSB = 3;
  localparam int RSV_MSB = 2;
  localparam int RSV_LSB = 1;
  localparam int OPQ_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Coordinates arrive one bit wider than the screen so overflow clips instead of wrapping.
  function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py);
    return (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after the
// pointer, wrapping around.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned j;
    j       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr_i) + i) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Shares one sprite ROM port and the VGA pixel write port among NUM_REQ
// sprite drawers: arbitrates, sequences ROM addresses and emits clipped pixels.
module sprite_draw_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int ENTRY_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_erase,
  input  logic [8*NUM_REQ-1:0]      req_x,
  input  logic [7*NUM_REQ-1:0]      req_y,
  input  logic [ADDR_W*NUM_REQ-1:0] req_base,
  input  logic [ADDR_W*NUM_REQ-1:0] req_len,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      done,
  output logic                      busy,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [ENTRY_W-1:0]        rom_data,
  output logic [7:0]                x,
  output logic [6:0]                y,
  output logic [2:0]                colour,
  output logic                      writeEn
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [ADDR_W-1:0]   rom_addr_q, cnt_q, len_q;
  logic [7:0]          org_x_q, x_q;
  logic [6:0]          org_y_q, y_q;
  logic [2:0]          colour_q;
  logic                erase_q, drain_q, vld_q, done_q, we_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [PTR_W-1:0]    arb_idx;
  logic                arb_valid;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  logic [7:0]        sel_x;
  logic [6:0]        sel_y;
  logic [ADDR_W-1:0] sel_base, sel_len;
  logic              sel_erase;

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_base  = '0;
    sel_len   = '0;
    sel_erase = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_x     = req_x[i*8 +: 8];
        sel_y     = req_y[i*7 +: 7];
        sel_base  = req_base[i*ADDR_W +: ADDR_W];
        sel_len   = req_len[i*ADDR_W +: ADDR_W];
        sel_erase = req_erase[i];
      end
    end
  end

  logic [8:0] px;
  logic [7:0] py;
  logic       pix_we;
  logic       unused_rsvd;

  assign px          = {1'b0, org_x_q} + 9'(rom_data[DX_MSB:DX_LSB]);
  assign py          = {1'b0, org_y_q} + 8'(rom_data[DY_MSB:DY_LSB]);
  assign pix_we      = vld_q && rom_data[OPQ_BIT] && on_screen(px, py);
  assign unused_rsvd = ^rom_data[RSV_MSB:RSV_LSB];

  // vld_q marks cycles where rom_data holds an entry addressed during DRAW.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      rom_addr_q <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      org_x_q    <= '0;
      org_y_q    <= '0;
      erase_q    <= 1'b0;
      drain_q    <= 1'b0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
    end else begin
      done_q <= 1'b0;
      vld_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            state_q    <= ST_DRAW;
            grant_q    <= arb_gnt;
            org_x_q    <= sel_x;
            org_y_q    <= sel_y;
            erase_q    <= sel_erase;
            len_q      <= sel_len;
            rom_addr_q <= sel_base;
            cnt_q      <= '0;
            ptr_q      <= PTR_W'((32'(arb_idx) + 1) % NUM_REQ);
          end
        end
        ST_DRAW: begin
          if (len_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            vld_q <= 1'b1;
            if (cnt_q == len_q - ADDR_W'(1)) begin
              state_q <= ST_DRAIN;
              drain_q <= 1'b0;
            end else begin
              cnt_q      <= cnt_q + ADDR_W'(1);
              rom_addr_q <= rom_addr_q + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase

      we_q <= pix_we;
      if (pix_we) begin
        x_q      <= px[7:0];
        y_q      <= py[6:0];
        colour_q <= erase_q ? 3'b000 : rom_data[COL_MSB:COL_LSB];
      end
    end
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);
  assign rom_addr = rom_addr_q;
  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign writeEn  = we_q;

endmodule
